// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared constants and FSM encoding for the bit-serial adder
package adder_pkg;

    // Default operand width of the serial adder.
    localparam int ADDER_WIDTH = 8;

    // Sequencer states: waiting for operands, shifting bits, holding result.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } adder_state_t;

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - one-bit full adder cell
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    // Single-bit sum and carry from three equally weighted inputs.
    always_comb begin
        sum  = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder, LSB first, one full adder cell reused WIDTH times
module serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    // Counter only has to reach WIDTH-1, so clog2(WIDTH) bits never wrap.
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    adder_state_t     state;
    adder_state_t     state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             cell_sum;
    logic             cell_cout;
    logic             accept;
    logic             last_bit;

    assign accept   = in_valid && (state == ST_IDLE);
    assign last_bit = (cnt == CNT_LAST);

    // The only adder logic: the current LSBs plus the running carry.
    full_adder u_cell (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .sum  (cell_sum),
        .cout (cell_cout)
    );

    // State register; reset abandons any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: accept in IDLE, leave RUN after the WIDTH-th bit, release DONE on out_ready.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (in_valid)  state_nxt = ST_RUN;
            ST_RUN:  if (last_bit)  state_nxt = ST_DONE;
            ST_DONE: if (out_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: load on accept, shift one bit per RUN cycle, hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
        end else if (state == ST_RUN) begin
            // Sum bits enter at the MSB so bit 0 lands at the LSB after WIDTH shifts.
            sum_sh <= {cell_sum, sum_sh[WIDTH-1:1]};
            carry  <= cell_cout;
            a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
            b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
            if (!last_bit) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Handshake and result outputs decoded straight from registered state.
    always_comb begin
        in_ready  = (state == ST_IDLE);
        out_valid = (state == ST_DONE);
        busy      = (state == ST_RUN) || (state == ST_DONE);
        sum       = sum_sh;
        cout      = carry;
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed self-checking bench for serial_adder
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
    } vec_t;

    vec_t vecs[8];

    serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
        @(negedge clk);
        a = av;
        b = bv;
        cin = cv;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output bit ok);
        cyc = 0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic release_result();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check("release_in_ready", 64'(in_ready), 64'd1);
        check("release_out_valid", 64'(out_valid), 64'd0);
    endtask

    initial begin
        int cyc;
        bit ok;
        logic [W-1:0] held_sum;
        logic         held_cout;

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[5] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
        vecs[6] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
        vecs[7] = '{8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0};

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_sum", 64'(sum), 64'd0);
        check("reset_cout", 64'(cout), 64'd0);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].cin);
            wait_done(cyc, ok);
            check($sformatf("vec%0d_done", i), 64'(ok), 64'd1);
            check($sformatf("vec%0d_latency", i), 64'(cyc), 64'd8);
            check($sformatf("vec%0d_sum", i), 64'(sum), 64'(vecs[i].exp_sum));
            check($sformatf("vec%0d_cout", i), 64'(cout), 64'(vecs[i].exp_cout));
            release_result();
        end

        // Backpressure: result must hold while out_ready stays low.
        send(8'h5A, 8'h3C, 1'b0);
        wait_done(cyc, ok);
        check("bp_done", 64'(ok), 64'd1);
        held_sum = sum;
        held_cout = cout;
        check("bp_sum", 64'(held_sum), 64'h96);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("bp%0d_out_valid", i), 64'(out_valid), 64'd1);
            check($sformatf("bp%0d_sum", i), 64'(sum), 64'h96);
            check($sformatf("bp%0d_cout", i), 64'(cout), 64'(held_cout));
            check($sformatf("bp%0d_in_ready", i), 64'(in_ready), 64'd0);
        end
        release_result();

        // Operands offered during RUN must be ignored.
        send(8'h5A, 8'h3C, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        a = 8'h11;
        b = 8'h11;
        cin = 1'b1;
        in_valid = 1'b1;
        check("ign_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_done(cyc, ok);
        check("ign_done", 64'(ok), 64'd1);
        check("ign_sum", 64'(sum), 64'h96);
        check("ign_cout", 64'(cout), 64'd0);
        release_result();
        @(negedge clk);
        check("ign_no_second_op", 64'(busy), 64'd0);

        // Reset in the middle of RUN, then an immediate new operation.
        send(8'hFF, 8'h01, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("abort_busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        check("abort_sum", 64'(sum), 64'd0);
        check("abort_cout", 64'(cout), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd1);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        a = 8'h01;
        b = 8'h02;
        cin = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_done(cyc, ok);
        check("post_rst_done", 64'(ok), 64'd1);
        check("post_rst_latency", 64'(cyc), 64'd8);
        check("post_rst_sum", 64'(sum), 64'h03);
        check("post_rst_cout", 64'(cout), 64'd0);
        release_result();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
